// File: rtl/connect_four_pkg.sv
// Shared board constants and display-scanner state encoding for the connect-four datapath.
// Pure definitions: no logic, no timing.
package connect_four_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY   = 2'b00;
    localparam cell_t PLAYER1 = 2'b01;
    localparam cell_t PLAYER2 = 2'b10;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/board_display_scanner_if.sv
// Board read port, player/cursor status and LED-matrix drive signals of the display scanner.
// Master = scanner, slave = game core plus external shift-register chain.
interface board_display_scanner_if;
    import connect_four_pkg::*;

    logic [2:0] row_read;
    logic [2:0] col_read;
    cell_t      cell_data;
    logic [2:0] cursor_col;
    cell_t      cursor_player;
    logic       game_over;

    logic       sr_data_r;
    logic       sr_data_g;
    logic       sr_clk;
    logic       sr_latch;
    logic [7:0] row_en;
    logic       frame_done;

    modport master (
        output row_read, col_read, sr_data_r, sr_data_g, sr_clk, sr_latch, row_en, frame_done,
        input  cell_data, cursor_col, cursor_player, game_over
    );

    modport slave (
        input  row_read, col_read, sr_data_r, sr_data_g, sr_clk, sr_latch, row_en, frame_done,
        output cell_data, cursor_col, cursor_player, game_over
    );

endinterface

// File: rtl/matrix_serializer.sv
// Shifts an 8-bit red/green word pair out LSB first on a divided shift clock.
// Busy for 16*CLK_DIV cycles after start_i; done_o marks the last busy cycle; no backpressure.
module matrix_serializer #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] red_i,
    input  logic [7:0] green_i,
    output logic       sr_data_r_o,
    output logic       sr_data_g_o,
    output logic       sr_clk_o,
    output logic       done_o
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          busy_q, busy_d;
    logic          phase_q, phase_d;
    logic [2:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [7:0]    red_q, red_d;
    logic [7:0]    green_q, green_d;
    logic          div_end;

    assign div_end = (div_q == DW'(CLK_DIV - 1));

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        div_d   = div_q;
        red_d   = red_q;
        green_d = green_q;
        if (start_i) begin
            busy_d  = 1'b1;
            phase_d = 1'b0;
            bit_d   = 3'd0;
            div_d   = '0;
            red_d   = red_i;
            green_d = green_i;
        end else if (busy_q) begin
            if (div_end) begin
                div_d   = '0;
                phase_d = ~phase_q;
                // data only advances on the falling edge so it is stable across the rising one
                if (phase_q) begin
                    bit_d   = bit_q + 3'd1;
                    red_d   = red_q >> 1;
                    green_d = green_q >> 1;
                    if (bit_q == 3'd7) begin
                        busy_d = 1'b0;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            bit_q   <= 3'd0;
            div_q   <= '0;
            red_q   <= 8'd0;
            green_q <= 8'd0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            red_q   <= red_d;
            green_q <= green_d;
        end
    end

    assign sr_data_r_o = busy_q & red_q[0];
    assign sr_data_g_o = busy_q & green_q[0];
    assign sr_clk_o    = busy_q & phase_q;
    assign done_o      = busy_q & div_end & phase_q & (bit_q == 3'd7);

endmodule

// File: rtl/board_display_scanner.sv
// Scans the game board row by row into red/green LED shift chains with cursor and game-over blink.
// Row period 8+READ_LAT + 16*CLK_DIV + 1 + HOLD_CYCLES cycles; free running, no backpressure.
module board_display_scanner
    import connect_four_pkg::*;
#(
    parameter int READ_LAT    = 1,
    parameter int CLK_DIV     = 2,
    parameter int HOLD_CYCLES = 64,
    parameter int BLINK_BITS  = 4
) (
    input  logic clk,
    input  logic rst,
    board_display_scanner_if.master bus
);

    localparam int FETCH_CYCLES = COLS + READ_LAT;
    localparam int CNT_MAX      = (HOLD_CYCLES > FETCH_CYCLES) ? HOLD_CYCLES : FETCH_CYCLES;
    localparam int CW           = $clog2(CNT_MAX + 1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            d_q, d_d;
    logic [BLINK_BITS-1:0] frame_q, frame_d;
    logic [7:0]            red_buf_q, red_buf_d;
    logic [7:0]            grn_buf_q, grn_buf_d;
    logic [2:0]            cur_col_q, cur_col_d;
    cell_t                 cur_ply_q, cur_ply_d;
    logic                  go_q, go_d;
    logic [7:0]            row_en_q, row_en_d;

    logic       ser_start;
    logic       ser_done;
    logic       blink;
    logic [2:0] cap_idx;
    logic [7:0] red_w, grn_w;

    assign blink   = frame_q[BLINK_BITS-1];
    assign cap_idx = 3'(cnt_q - CW'(READ_LAT));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        frame_d   = frame_q;
        red_buf_d = red_buf_q;
        grn_buf_d = grn_buf_q;
        cur_col_d = cur_col_q;
        cur_ply_d = cur_ply_q;
        go_d      = go_q;
        row_en_d  = row_en_q;
        ser_start = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (cnt_q == '0) begin
                    cur_col_d = bus.cursor_col;
                    cur_ply_d = bus.cursor_player;
                    go_d      = bus.game_over;
                end
                if (cnt_q >= CW'(READ_LAT)) begin
                    red_buf_d[cap_idx] = (bus.cell_data == PLAYER1);
                    grn_buf_d[cap_idx] = (bus.cell_data == PLAYER2);
                end
                if (cnt_q == CW'(FETCH_CYCLES - 1)) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    ser_start = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ser_done) begin
                    state_d  = ST_LATCH;
                    row_en_d = 8'b1 << d_q;
                end
            end
            ST_LATCH: begin
                state_d = ST_HOLD;
                cnt_d   = '0;
                d_d     = d_q + 3'd1;
                if (d_q == 3'd7) begin
                    frame_d = frame_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                    state_d = ST_FETCH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Overlay reads the _d buffers so the cell captured on the final fetch cycle is included.
    always_comb begin
        red_w = red_buf_d;
        grn_w = grn_buf_d;
        if ((d_q == 3'd0) && blink && !red_w[cur_col_q] && !grn_w[cur_col_q]) begin
            red_w[cur_col_q] = (cur_ply_q == PLAYER1);
            grn_w[cur_col_q] = (cur_ply_q == PLAYER2);
        end
        if (go_q && !blink) begin
            red_w = 8'd0;
            grn_w = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            cnt_q     <= '0;
            d_q       <= 3'd0;
            frame_q   <= '0;
            red_buf_q <= 8'd0;
            grn_buf_q <= 8'd0;
            cur_col_q <= 3'd0;
            cur_ply_q <= EMPTY;
            go_q      <= 1'b0;
            row_en_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            frame_q   <= frame_d;
            red_buf_q <= red_buf_d;
            grn_buf_q <= grn_buf_d;
            cur_col_q <= cur_col_d;
            cur_ply_q <= cur_ply_d;
            go_q      <= go_d;
            row_en_q  <= row_en_d;
        end
    end

    matrix_serializer #(
        .CLK_DIV (CLK_DIV)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .start_i     (ser_start),
        .red_i       (red_w),
        .green_i     (grn_w),
        .sr_data_r_o (bus.sr_data_r),
        .sr_data_g_o (bus.sr_data_g),
        .sr_clk_o    (bus.sr_clk),
        .done_o      (ser_done)
    );

    // The address must already be row 7 in the first post-reset cycle yet read 0 while in reset.
    assign bus.row_read   = rst ? 3'd0 : (3'(ROWS - 1) - d_q);
    assign bus.col_read   = ((state_q == ST_FETCH) && (cnt_q < CW'(COLS))) ? cnt_q[2:0] : 3'd0;
    assign bus.sr_latch   = (state_q == ST_LATCH);
    assign bus.frame_done = (state_q == ST_LATCH) && (d_q == 3'd7);
    assign bus.row_en     = row_en_q;

endmodule

// File: tb/tb_board_display_scanner.sv
// Directed bench: default scanner on a 1-cycle board model plus a READ_LAT=2 scanner on a 2-cycle model.
module tb_board_display_scanner;
    import connect_four_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    board_display_scanner_if bus ();
    board_display_scanner_if bus2 ();

    board_display_scanner #(
        .READ_LAT (1), .CLK_DIV (2), .HOLD_CYCLES (64), .BLINK_BITS (4)
    ) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    board_display_scanner #(
        .READ_LAT (2), .CLK_DIV (2), .HOLD_CYCLES (64), .BLINK_BITS (4)
    ) dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );

    cell_t board  [8][8];
    cell_t board2 [8][8];
    cell_t rd1_q  = EMPTY;
    cell_t rd2a_q = EMPTY;
    cell_t rd2b_q = EMPTY;

    always @(posedge clk) begin
        rd1_q  <= board[bus.row_read][bus.col_read];
        rd2a_q <= board2[bus2.row_read][bus2.col_read];
        rd2b_q <= rd2a_q;
    end
    assign bus.cell_data  = rd1_q;
    assign bus2.cell_data = rd2b_q;

    logic [7:0] sh_r = 8'd0, sh_g = 8'd0, sh2_r = 8'd0, sh2_g = 8'd0;
    logic       prev_clk = 1'b0, prev_clk2 = 1'b0;
    int         fd_cnt = 0;
    int         lat2_n = 0;
    logic [7:0] rec2_r [8];
    logic [7:0] rec2_g [8];

    always @(negedge clk) begin
        prev_clk  <= bus.sr_clk;
        prev_clk2 <= bus2.sr_clk;
        if (bus.sr_clk && !prev_clk) begin
            sh_r <= {bus.sr_data_r, sh_r[7:1]};
            sh_g <= {bus.sr_data_g, sh_g[7:1]};
        end
        if (bus2.sr_clk && !prev_clk2) begin
            sh2_r <= {bus2.sr_data_r, sh2_r[7:1]};
            sh2_g <= {bus2.sr_data_g, sh2_g[7:1]};
        end
        if (bus.frame_done) fd_cnt <= fd_cnt + 1;
        if (bus2.sr_latch && lat2_n < 8) begin
            rec2_r[lat2_n] <= sh2_r;
            rec2_g[lat2_n] <= sh2_g;
            lat2_n         <= lat2_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto_latch(input int target, inout int n);
        bit ok;
        while (n < target) begin
            ok = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                #1;
                if (bus.sr_latch) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_assert++;
            assert (ok) else begin
                n_fail++;
                $error("FAIL latch_wait: no latch within 200 cycles, at latch %0d expected %0d", n, n + 1);
            end
            n = ok ? n + 1 : target;
        end
    endtask

    task automatic check_row(input string tag, input logic [7:0] ren, input logic [7:0] r, input logic [7:0] g);
        check({tag, "_row_en"}, bus.row_en, ren);
        check({tag, "_red"}, sh_r, r);
        check({tag, "_green"}, sh_g, g);
    endtask

    initial begin
        int   lat_n;
        int   first;
        logic any;

        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                board[r][c]  = EMPTY;
                board2[r][c] = EMPTY;
            end
        end
        board2[7][0] = PLAYER1; board2[7][1] = PLAYER2; board2[7][3] = 2'b11;
        board2[7][4] = PLAYER2; board2[7][5] = PLAYER1; board2[7][6] = PLAYER1;
        board2[7][7] = PLAYER2;
        for (int c = 0; c < 8; c++) board2[6][c] = (c == 3) ? PLAYER1 : PLAYER2;

        bus.cursor_col     = 3'd3;
        bus.cursor_player  = PLAYER1;
        bus.game_over      = 1'b0;
        bus2.cursor_col    = 3'd2;
        bus2.cursor_player = PLAYER1;
        bus2.game_over     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.row_en, bus.row_read, bus.col_read, bus.sr_data_r,
                                bus.sr_data_g, bus.sr_clk, bus.sr_latch, bus.frame_done}, 32'd0);
        check("reset_row_read2", bus2.row_read, 3'd0);

        @(posedge clk);
        #1 rst = 1'b0;
        any = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            any = any | (bus.row_en != 8'd0) | bus.sr_latch;
            if (k == 1) begin
                check("first_fetch_addr", {bus.row_read, bus.col_read}, {3'd7, 3'd0});
                check("first_fetch_row2", bus2.row_read, 3'd7);
            end
            if (k == 3)  check("fetch_col2", bus.col_read, 3'd2);
            if (k == 10) check("shift_lo_c10", bus.sr_clk, 1'b0);
            if (k == 12) begin
                check("shift_hi_c12", bus.sr_clk, 1'b1);
                check("lat2_shift_lo_c12", bus2.sr_clk, 1'b0);
            end
            if (k == 13) check("lat2_shift_hi_c13", bus2.sr_clk, 1'b1);
        end
        check("row_en_quiet_41", any, 1'b0);

        @(negedge clk);
        #1;
        check("latch42", {bus.sr_latch, bus.frame_done}, 2'b10);
        check_row("row0_empty", 8'h01, 8'h00, 8'h00);
        lat_n = 1;

        @(negedge clk);
        #1;
        check("lat2_latch43", {bus2.sr_latch, bus2.row_en}, {1'b1, 8'h01});
        check("lat2_row0", {sh2_r, sh2_g}, {8'h61, 8'h92});
        check("hold_outputs", {bus.sr_latch, bus.row_en}, {1'b0, 8'h01});

        board[7][0] = PLAYER1;
        board[7][7] = PLAYER2;

        goto_latch(8, lat_n);
        check("frame_done_row7", {bus.frame_done, bus.row_en}, {1'b1, 8'h80});
        check("frame_done_count8", fd_cnt, 1);
        check("lat2_row1", {rec2_r[1], rec2_g[1]}, {8'h08, 8'hF7});

        goto_latch(9, lat_n);
        check_row("f1_phase0", 8'h01, 8'h01, 8'h80);

        goto_latch(65, lat_n);
        check_row("f8_cursor_p1", 8'h01, 8'h09, 8'h80);
        bus.cursor_player = PLAYER2;

        goto_latch(73, lat_n);
        check_row("f9_cursor_p2", 8'h01, 8'h01, 8'h88);
        bus.cursor_col = 3'd0;

        goto_latch(81, lat_n);
        check_row("f10_cursor_occupied", 8'h01, 8'h01, 8'h80);
        bus.cursor_col = 3'd3;

        goto_latch(121, lat_n);
        check_row("f15_cursor_on", 8'h01, 8'h01, 8'h88);

        goto_latch(129, lat_n);
        check_row("f16_cursor_off", 8'h01, 8'h01, 8'h80);
        check("frame_done_count128", fd_cnt, 16);

        bus.game_over = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) board[r][c] = ((r + c) % 2 == 1) ? PLAYER2 : PLAYER1;
        end

        goto_latch(130, lat_n);
        check_row("go_phase0_blank", 8'h02, 8'h00, 8'h00);

        goto_latch(193, lat_n);
        check_row("go_phase1_row0", 8'h01, 8'hAA, 8'h55);

        goto_latch(194, lat_n);
        check_row("go_phase1_row1", 8'h02, 8'h55, 8'hAA);

        goto_latch(195, lat_n);
        check_row("go_phase1_row2", 8'h04, 8'hAA, 8'h55);

        repeat (76) @(negedge clk);
        #1;
        check("pre_rst_mid_shift", {bus.sr_clk, bus.row_en}, {1'b1, 8'h04});
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {bus.row_en, bus.row_read, bus.sr_data_r, bus.sr_data_g,
                                    bus.sr_clk, bus.sr_latch, bus.frame_done}, 32'd0);
        bus.game_over = 1'b0;

        @(posedge clk);
        #1 rst = 1'b0;
        first = 0;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 1) check("restart_addr", {bus.row_read, bus.col_read, bus.row_en}, {3'd7, 3'd0, 8'h00});
            if (bus.sr_latch && first == 0) first = k;
        end
        #1;
        check("restart_latch_cycle", first, 42);
        check_row("restart_row0", 8'h01, 8'hAA, 8'h55);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
